// File: rtl/spec_mult_pkg.sv
// Shared constants, framing types and the round/saturate helper for the
// frequency-domain filter stage.
package spec_mult_pkg;
    localparam int NPT       = 256;
    localparam int AW        = 8;
    localparam int DW        = 16;
    localparam int OUT_SHIFT = 15;
    localparam int EXP_W     = 6;
    localparam int PW        = 2*DW + 1;

    localparam int SAT_HI = 2**(DW-1) - 1;
    localparam int SAT_LO = -(2**(DW-1));

    localparam logic [AW-1:0]        LAST_BIN = AW'(NPT - 1);
    localparam logic signed [PW-1:0] RND      = PW'(2**(OUT_SHIFT-1));

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    typedef struct packed {
        logic             sop;
        logic             eop;
        logic [EXP_W-1:0] exp;
    } tag_t;

    // Round half up, drop the Q1.15 fraction, clamp to the DW-bit range.
    function automatic logic signed [DW-1:0] round_sat(input logic signed [PW-1:0] v);
        logic signed [PW-1:0] s;
        s = (v + RND) >>> OUT_SHIFT;
        if (s > PW'(SAT_HI))
            return DW'(SAT_HI);
        else if (s < PW'(SAT_LO))
            return DW'(SAT_LO);
        else
            return s[DW-1:0];
    endfunction
endpackage

// File: rtl/spec_mult_if.sv
// Bin stream in/out, coefficient write port and framing error flag.
interface spec_mult_if;
    import spec_mult_pkg::*;

    logic                    in_valid;
    logic                    in_sop;
    logic                    in_eop;
    logic signed [DW-1:0]    in_re;
    logic signed [DW-1:0]    in_im;
    logic [EXP_W-1:0]        in_exp;
    logic                    coef_we;
    logic [AW-1:0]           coef_addr;
    logic signed [DW-1:0]    coef_re;
    logic signed [DW-1:0]    coef_im;
    logic                    out_valid;
    logic                    out_sop;
    logic                    out_eop;
    logic signed [DW-1:0]    out_re;
    logic signed [DW-1:0]    out_im;
    logic [EXP_W-1:0]        out_exp;
    logic                    frame_err;

    modport master (
        output in_valid, in_sop, in_eop, in_re, in_im, in_exp,
        output coef_we, coef_addr, coef_re, coef_im,
        input  out_valid, out_sop, out_eop, out_re, out_im, out_exp, frame_err
    );

    modport slave (
        input  in_valid, in_sop, in_eop, in_re, in_im, in_exp,
        input  coef_we, coef_addr, coef_re, coef_im,
        output out_valid, out_sop, out_eop, out_re, out_im, out_exp, frame_err
    );
endinterface

// File: rtl/cmul_rs.sv
// Two-stage complex multiply: registered partial products, then combine,
// round, saturate and register the output bin with its framing tag.
module cmul_rs
    import spec_mult_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 in_vld,
    input  tag_t                 in_tag,
    input  logic signed [DW-1:0] a,
    input  logic signed [DW-1:0] b,
    input  logic signed [DW-1:0] c,
    input  logic signed [DW-1:0] d,
    output logic                 out_vld,
    output tag_t                 out_tag,
    output logic signed [DW-1:0] y_re,
    output logic signed [DW-1:0] y_im
);
    logic                   s2_vld_q, s2_vld_d;
    tag_t                   s2_tag_q, s2_tag_d;
    logic signed [2*DW-1:0] ac_q, ac_d, bd_q, bd_d, ad_q, ad_d, bc_q, bc_d;
    logic signed [PW-1:0]   sum_re, sum_im;
    logic                   out_vld_q, out_vld_d;
    tag_t                   out_tag_q, out_tag_d;
    logic signed [DW-1:0]   y_re_q, y_re_d, y_im_q, y_im_d;

    always_comb begin
        s2_vld_d = in_vld;
        s2_tag_d = in_tag;
        ac_d     = (2*DW)'(a) * (2*DW)'(c);
        bd_d     = (2*DW)'(b) * (2*DW)'(d);
        ad_d     = (2*DW)'(a) * (2*DW)'(d);
        bc_d     = (2*DW)'(b) * (2*DW)'(c);

        sum_re    = PW'(ac_q) - PW'(bd_q);
        sum_im    = PW'(ad_q) + PW'(bc_q);
        out_vld_d = s2_vld_q;
        // Exponent holds between bins; sop/eop are single-bin markers.
        out_tag_d     = out_tag_q;
        out_tag_d.sop = 1'b0;
        out_tag_d.eop = 1'b0;
        y_re_d        = y_re_q;
        y_im_d        = y_im_q;
        if (s2_vld_q) begin
            out_tag_d = s2_tag_q;
            y_re_d    = round_sat(sum_re);
            y_im_d    = round_sat(sum_im);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s2_vld_q  <= 1'b0;
            s2_tag_q  <= '0;
            ac_q      <= '0;
            bd_q      <= '0;
            ad_q      <= '0;
            bc_q      <= '0;
            out_vld_q <= 1'b0;
            out_tag_q <= '0;
            y_re_q    <= '0;
            y_im_q    <= '0;
        end else begin
            s2_vld_q  <= s2_vld_d;
            s2_tag_q  <= s2_tag_d;
            ac_q      <= ac_d;
            bd_q      <= bd_d;
            ad_q      <= ad_d;
            bc_q      <= bc_d;
            out_vld_q <= out_vld_d;
            out_tag_q <= out_tag_d;
            y_re_q    <= y_re_d;
            y_im_q    <= y_im_d;
        end
    end

    assign out_vld = out_vld_q;
    assign out_tag = out_tag_q;
    assign y_re    = y_re_q;
    assign y_im    = y_im_q;
endmodule

// File: rtl/spec_mult.sv
// Filter stage Y[k] = X[k]*H[k]: framing FSM, bin counter, coefficient
// table and S1 register; cmul_rs supplies the remaining two stages.
module spec_mult
    import spec_mult_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    spec_mult_if.slave bus
);
    // state | meaning
    // IDLE  | between frames; sop starts a frame, anything else is dropped and flagged
    // RUN   | inside a frame; each accepted bin advances the counter

    state_t               state_q, state_d;
    logic [AW-1:0]        bin_q, bin_d, cur_bin;
    logic [EXP_W-1:0]     exp_q, exp_d;
    logic                 err_q, err_d;
    logic                 accept;
    logic                 s1_vld_q, s1_vld_d;
    tag_t                 s1_tag_q, s1_tag_d;
    logic signed [DW-1:0] s1_re_q, s1_re_d, s1_im_q, s1_im_d;
    logic [2*DW-1:0]      coef_mem [NPT];
    logic [2*DW-1:0]      h_q;
    logic                 cm_vld;
    tag_t                 cm_tag;
    logic signed [DW-1:0] cm_re, cm_im;

    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        exp_d   = exp_q;
        err_d   = 1'b0;
        accept  = 1'b0;
        cur_bin = bin_q;
        if (bus.in_valid) begin
            if (state_q == IDLE && !bus.in_sop) begin
                err_d = 1'b1;
            end else begin
                accept = 1'b1;
                if (bus.in_sop) begin
                    cur_bin = '0;
                    exp_d   = bus.in_exp;
                    err_d   = (state_q == RUN);
                end
                if (bus.in_eop) begin
                    state_d = IDLE;
                    bin_d   = '0;
                    if (cur_bin != LAST_BIN) err_d = 1'b1;
                end else begin
                    // A missing eop is not synthesised; the counter just wraps.
                    state_d = RUN;
                    bin_d   = cur_bin + AW'(1);
                    if (cur_bin == LAST_BIN) err_d = 1'b1;
                end
            end
        end

        s1_vld_d = accept;
        s1_tag_d = '{sop: bus.in_sop, eop: bus.in_eop, exp: exp_d};
        s1_re_d  = bus.in_re;
        s1_im_d  = bus.in_im;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            bin_q    <= '0;
            exp_q    <= '0;
            err_q    <= 1'b0;
            s1_vld_q <= 1'b0;
            s1_tag_q <= '0;
            s1_re_q  <= '0;
            s1_im_q  <= '0;
        end else begin
            state_q  <= state_d;
            bin_q    <= bin_d;
            exp_q    <= exp_d;
            err_q    <= err_d;
            s1_vld_q <= s1_vld_d;
            s1_tag_q <= s1_tag_d;
            s1_re_q  <= s1_re_d;
            s1_im_q  <= s1_im_d;
        end
    end

    // Read-before-write: a same-cycle write to the bin being read returns the old H.
    always_ff @(posedge clk) begin
        if (bus.coef_we) coef_mem[bus.coef_addr] <= {bus.coef_re, bus.coef_im};
        h_q <= coef_mem[cur_bin];
    end

    cmul_rs u_cmul (
        .clk     (clk),
        .reset_n (reset_n),
        .in_vld  (s1_vld_q),
        .in_tag  (s1_tag_q),
        .a       (s1_re_q),
        .b       (s1_im_q),
        .c       ($signed(h_q[2*DW-1:DW])),
        .d       ($signed(h_q[DW-1:0])),
        .out_vld (cm_vld),
        .out_tag (cm_tag),
        .y_re    (cm_re),
        .y_im    (cm_im)
    );

    assign bus.out_valid = cm_vld;
    assign bus.out_sop   = cm_tag.sop;
    assign bus.out_eop   = cm_tag.eop;
    assign bus.out_exp   = cm_tag.exp;
    assign bus.out_re    = cm_re;
    assign bus.out_im    = cm_im;
    assign bus.frame_err = err_q;
endmodule

// File: tb/tb_spec_mult.sv
// Randomized bench for spec_mult against a frame-level reference model.
module tb_spec_mult;
    import spec_mult_pkg::*;

    typedef struct {
        int due;
        int re;
        int im;
        bit sop;
        bit eop;
        int ex;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    spec_mult_if bus ();
    spec_mult dut (.clk(clk), .reset_n(reset_n), .bus(bus));

    always #5 clk = ~clk;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   edge_n = 0;
    exp_t exq[$];
    bit   err_at[int];
    int   hm_re[NPT];
    int   hm_im[NPT];
    bit   m_run = 1'b0;
    int   m_bin = 0;
    int   m_exp = 0;
    bit   nx_we = 1'b0;
    int   nx_addr = 0, nx_re = 0, nx_im = 0;

    task automatic chk(string tag, int obs, int want);
        n_cmp++;
        if (obs != want) begin
            n_bad++;
            $display("FAIL %s @edge %0d: got %0d, want %0d", tag, edge_n, obs, want);
        end
    endtask

    function automatic int rnd16();
        logic signed [15:0] t;
        t = 16'($urandom);
        return int'(t);
    endfunction

    // Floor((v + 2^14) / 2^15), clamped to 16-bit signed.
    function automatic int rsat(longint v);
        longint r;
        r = (v + 64'sd16384) >>> 15;
        if (r > 32767) return 32767;
        if (r < -32768) return -32768;
        return int'(r);
    endfunction

    task automatic drive(bit v, bit sop, bit eop, int re, int im, int ex);
        int e, b;
        bit err;
        @(negedge clk);
        bus.in_valid  = v;
        bus.in_sop    = sop;
        bus.in_eop    = eop;
        bus.in_re     = 16'(re);
        bus.in_im     = 16'(im);
        bus.in_exp    = EXP_W'(ex);
        bus.coef_we   = nx_we;
        bus.coef_addr = AW'(nx_addr);
        bus.coef_re   = 16'(nx_re);
        bus.coef_im   = 16'(nx_im);
        e = edge_n + 1;
        if (v) begin
            if (!m_run && !sop) begin
                err_at[e] = 1'b1;
            end else begin
                err = 1'b0;
                if (sop) begin
                    err   = m_run;
                    b     = 0;
                    m_exp = ex;
                end else begin
                    b = m_bin;
                end
                if (eop) begin
                    m_run = 1'b0;
                    err |= (b != NPT-1);
                end else begin
                    m_run = 1'b1;
                    err |= (b == NPT-1);
                    m_bin = (b + 1) % NPT;
                end
                if (err) err_at[e] = 1'b1;
                exq.push_back('{e + 2,
                    rsat(longint'(re) * hm_re[b] - longint'(im) * hm_im[b]),
                    rsat(longint'(re) * hm_im[b] + longint'(im) * hm_re[b]),
                    sop, eop, m_exp});
            end
        end
        // The table update lands after this edge's read.
        if (nx_we) begin
            hm_re[nx_addr] = nx_re;
            hm_im[nx_addr] = nx_im;
        end
        nx_we = 1'b0;
    endtask

    task automatic wr_coef(int a, int r, int i);
        nx_we = 1'b1; nx_addr = a; nx_re = r; nx_im = i;
        drive(1'b0, 1'b0, 1'b0, 0, 0, 0);
    endtask

    task automatic fill_const(int r, int i);
        for (int a = 0; a < NPT; a++) wr_coef(a, r, i);
    endtask

    task automatic fill_rand();
        for (int a = 0; a < NPT; a++) wr_coef(a, rnd16(), rnd16());
    endtask

    task automatic send_bins(int n, bit first_sop, bit last_eop, int ex, bit gaps, bit writes);
        bit s;
        for (int i = 0; i < n; i++) begin
            if (gaps) repeat ($urandom_range(0, 2)) drive(1'b0, 1'b0, 1'b0, 0, 0, 0);
            if (writes && $urandom_range(0, 7) == 0) begin
                nx_we   = 1'b1;
                nx_addr = ($urandom_range(0, 1) == 0) ? m_bin : int'($urandom_range(0, NPT-1));
                nx_re   = rnd16();
                nx_im   = rnd16();
            end
            s = first_sop && (i == 0);
            drive(1'b1, s, last_eop && (i == n-1), rnd16(), rnd16(),
                  s ? ex : int'($urandom_range(0, 63)));
        end
    endtask

    task automatic do_reset(int n);
        @(negedge clk);
        reset_n       = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_sop    = 1'b0;
        bus.in_eop    = 1'b0;
        bus.coef_we   = 1'b0;
        exq.delete();
        err_at.delete();
        m_run = 1'b0;
        m_bin = 0;
        repeat (n) @(negedge clk);
        reset_n = 1'b1;
    endtask

    always @(posedge clk) begin
        exp_t e;
        bit   hit;
        edge_n++;
        #1;
        if (!reset_n) begin
            chk("reset_outs", int'(|{bus.out_valid, bus.out_sop, bus.out_eop, bus.out_re,
                                     bus.out_im, bus.out_exp, bus.frame_err}), 0);
        end else begin
            hit = exq.size() > 0 && exq[0].due == edge_n;
            chk("out_valid", int'(bus.out_valid), int'(hit));
            if (hit) begin
                e = exq.pop_front();
                chk("out_re", int'(bus.out_re), e.re);
                chk("out_im", int'(bus.out_im), e.im);
                chk("out_sop", int'(bus.out_sop), int'(e.sop));
                chk("out_eop", int'(bus.out_eop), int'(e.eop));
                chk("out_exp", int'(bus.out_exp), e.ex);
            end
            chk("frame_err", int'(bus.frame_err), int'(err_at.exists(edge_n)));
        end
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_sop    = 1'b0;
        bus.in_eop    = 1'b0;
        bus.in_re     = '0;
        bus.in_im     = '0;
        bus.in_exp    = '0;
        bus.coef_we   = 1'b0;
        bus.coef_addr = '0;
        bus.coef_re   = '0;
        bus.coef_im   = '0;
        do_reset(3);

        // H = 0.5 everywhere: constant frame, then rounding corner cases.
        fill_const(16384, 0);
        for (int i = 0; i < NPT; i++) drive(1'b1, i == 0, i == NPT-1, 1000, -2000, 7);
        drive(1'b1, 1'b1, 1'b0, 1, -1, 9);
        drive(1'b1, 1'b0, 1'b0, 3, -3, 0);
        send_bins(NPT-2, 1'b0, 1'b1, 9, 1'b0, 1'b0);

        // Saturation at bin 5, zero response elsewhere.
        fill_const(0, 0);
        wr_coef(5, 32767, -32767);
        send_bins(5, 1'b1, 1'b0, 2, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 32767, 32767, 0);
        send_bins(NPT-6, 1'b0, 1'b1, 0, 1'b0, 1'b0);

        // Framing faults over a random table.
        fill_rand();
        send_bins(100, 1'b1, 1'b0, 11, 1'b0, 1'b0);
        send_bins(NPT, 1'b1, 1'b1, 12, 1'b0, 1'b0);
        send_bins(201, 1'b1, 1'b1, 13, 1'b1, 1'b0);
        repeat (3) drive(1'b1, 1'b0, 1'b0, rnd16(), rnd16(), 0);
        drive(1'b0, 1'b0, 1'b0, 0, 0, 0);
        send_bins(NPT+4, 1'b1, 1'b1, 14, 1'b0, 1'b0);

        // Back-to-back frames with gaps and live table writes.
        send_bins(NPT, 1'b1, 1'b1, 3, 1'b1, 1'b1);
        send_bins(NPT, 1'b1, 1'b1, 5, 1'b1, 1'b1);

        // Reset in the middle of a frame, then a clean frame.
        send_bins(120, 1'b1, 1'b0, 20, 1'b0, 1'b0);
        do_reset(2);
        send_bins(NPT, 1'b1, 1'b1, 21, 1'b1, 1'b0);

        repeat (8) drive(1'b0, 1'b0, 1'b0, 0, 0, 0);
        chk("drain_left", exq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/spec_mult.md
Name: spec_mult

Overview:
- Frequency-domain filter stage of the 256-point overlap-add transform filter.
- Consumes the forward FFT output stream (sop/eop/valid, real/imag, block exponent) and multiplies each bin X[k] by a stored filter response H[k].
- Emits Y[k] = X[k]·H[k] as a 16-bit complex stream with aligned framing, ready for the IFFT/overlap-add output stage.
- H[k] sits in an internal 256-entry table, writable at run time.

Parameters:
- NPT, 256, points per frame; power of two.
- AW, 8, bin index width, log2(NPT).
- DW, 16, data and coefficient width; signed two's complement.
- OUT_SHIFT, 15, right shift applied to products; H is Q1.15.

Ports:
- clk  in  1  system clock, 64 MHz.
- reset_n  in  1  asynchronous reset, active low.
- in_valid  in  1  input bin valid.
- in_sop  in  1  first bin of frame; qualified by in_valid.
- in_eop  in  1  last bin of frame; qualified by in_valid.
- in_re  in  DW  X[k] real.
- in_im  in  DW  X[k] imag.
- in_exp  in  6  FFT block exponent; sampled with in_sop.
- coef_we  in  1  table write strobe.
- coef_addr  in  AW  table write index.
- coef_re  in  DW  H real, Q1.15.
- coef_im  in  DW  H imag, Q1.15.
- out_valid  out  1  output bin valid.
- out_sop  out  1  first bin of output frame.
- out_eop  out  1  last bin of output frame.
- out_re  out  DW  Y[k] real.
- out_im  out  DW  Y[k] imag.
- out_exp  out  6  exponent of the current output frame.
- frame_err  out  1  one-cycle framing error pulse.

Behaviour:
- Reset: all outputs 0, FSM to IDLE, bin counter 0, pipeline valid bits cleared. The coefficient table is not reset; its contents are undefined until written.
- FSM states:
  - IDLE: in_valid&in_sop starts a frame, bin=0, latches in_exp, goes to RUN. in_valid without sop: sample dropped, frame_err pulses.
  - RUN: each in_valid advances bin by 1.
  - in_valid&in_eop returns to IDLE. If bin≠NPT-1 at that point, frame_err pulses; the sample is still forwarded with its eop.
  - in_valid&in_sop while in RUN restarts the frame at bin 0 with a new exponent latch, and frame_err pulses.
  - Bin reaching NPT-1 without eop: eop is not synthesised. bin wraps to 0, frame_err pulses, FSM stays in RUN.
- Gaps: in_valid low stalls the counter. No back-pressure; the block is always ready.
- Pipeline: fixed latency 3 cycles from an accepted input to out_valid. Stage-level detail:
  - S1: register X, framing and bin; read H[bin].
  - S2: four DW×DW signed products.
  - S3: re = ac−bd, im = ad+bc (2·DW+1 bits); add 2^(OUT_SHIFT−1) (round half up); arithmetic shift right by OUT_SHIFT; saturate to [−32768, 32767]; register outputs.
- out_sop, out_eop and out_exp stay aligned with their bin through all stages. Dropped samples produce no output.
- Coefficient write/read:
  - Write takes effect on the next clock and is permitted while in RUN.
  - Write and read of the same address in the same cycle: the read returns the old value.
- reset_n asserted mid-frame: the in-flight frame is discarded with no partial outputs after release, and the FSM restarts in IDLE.

Decomposition:
- Package spec_mult_pkg holds:
  - Constants: NPT, AW, DW, OUT_SHIFT, EXP_W=6.
  - Saturation limits.
  - FSM state typedef {IDLE, RUN}.
- Sub-module cmul_rs: pipelined complex multiply with round and saturate (stages S2–S3).
- The table is inferred dual-port memory inside spec_mult.

Test Plan:
- Table all H=(0x4000,0); a 256-bin frame with X=(1000,−2000) → every output (500,−1000). out_valid 3 cycles after each input; out_sop on bin 0, out_eop on bin 255; frame_err never asserted.
- H[5]=(0x7FFF,0x8001), X[5]=(0x7FFF,0x7FFF) → out_re saturates to 32767, out_im=0. Other bins with H=0 → (0,0).
- Rounding with H=(0x4000,0): X=(1,−1) → (1,0); X=(3,−3) → (2,−1).
- Framing errors:
  - sop, 100 valid bins, then sop → frame_err pulse on the 101st accepted bin; the following bins index H from 0.
  - eop at bin 200 → frame_err pulse, then IDLE.
  - valid without sop in IDLE → frame_err pulse, no output.
- in_exp=6'd3 on frame A and 6'd5 on frame B, back-to-back with random valid gaps → out_exp matches per frame; output count equals input count.
- reset_n low for 2 cycles at bin 120 → all outputs 0 during reset. After release the next frame's bin 0 uses H[0], with no stale outputs.
